// File: rtl/prog_load_master_pkg.sv
// Shared types and constants for the program loader.
// Build option: PROG_LOAD_VERIFY_EN adds a read-back check per word.
package prog_load_master_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_DATA,
      S_WRITE,
      S_VERIFY,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_ALIGN   = 2'b10;
   localparam logic [1:0] ERR_VERIFY  = 2'b11;

   localparam logic [31:0] IO_UART_TX   = 32'h3000_0000;
   localparam logic [31:0] IO_UART_RX   = 32'h3000_0004;
   localparam logic [31:0] IO_UART_STAT = 32'h3000_0008;
   localparam logic [31:0] IO_LED       = 32'h3000_000C;
   localparam logic [31:0] IO_TIMER     = 32'h3000_0010;
   localparam logic [31:0] RAM_LIMIT    = 32'h0000_2000;

   // Byte address of word idx; wraps mod 2^32
   function automatic logic [31:0] word_addr(
      input logic [31:0] base,
      input logic [31:0] idx
   );
      return base + (idx << 2);
   endfunction

endpackage

// File: rtl/prog_load_master_if.sv
// Stream-in and native memory bus signals of the program loader.
interface prog_load_master_if;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      input  in_data, in_valid, mem_ready, mem_rdata,
      output in_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

   modport slave (
      output in_data, in_valid, mem_ready, mem_rdata,
      input  in_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/bus_txn_timer.sv
// Per-transaction wait counter; expired fires on the cycle it would
// reach TIMEOUT_CYC with no acknowledge.
module bus_txn_timer #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT_CYC + 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + W'(1);
   end

   assign expired = en && (cnt_q == W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/prog_load_master.sv
// Streams program words into RAM over the native bus, holding the core
// in reset meanwhile. Build option: PROG_LOAD_VERIFY_EN.
module prog_load_master
   import prog_load_master_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int CNT_W       = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [31:0]        base_addr,
   input  logic [CNT_W-1:0]   word_count,
   prog_load_master_if.master bus,
   output logic               core_hold,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [1:0]         err_code,
   output logic [31:0]        checksum
);
   state_t           state_q, state_d;
   logic [31:0]      base_q, base_d;
   logic [31:0]      word_q, word_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] idx_inc;
   logic [3:0]       wstrb_q, wstrb_d;
   logic [1:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic             rdy_q, rdy_d;
   logic             hold_q, hold_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             ack, in_txn;
   logic             tmr_clr, tmr_en, tmr_exp;

   // A ready pulse only counts against an outstanding request
   assign ack     = valid_q && bus.mem_ready;
   assign in_txn  = (state_q == S_WRITE) || (state_q == S_VERIFY);
   assign idx_inc = idx_q + CNT_W'(1);
   assign tmr_en  = in_txn && !ack;
   assign tmr_clr = (state_d != state_q);

   bus_txn_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_bus_txn_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_exp)
   );

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      word_d  = word_q;
      addr_d  = addr_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wstrb_d = wstrb_q;
      code_d  = code_q;
      valid_d = valid_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               base_d = base_addr;
               cnt_d  = word_count;
               sum_d  = '0;
               idx_d  = '0;
               code_d = ERR_NONE;
               if (base_addr[1:0] != 2'b00) begin
                  state_d = S_ERROR;
                  code_d  = ERR_ALIGN;
               end else if (word_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT_DATA;
               end
            end
         end
         S_WAIT_DATA: begin
            if (bus.in_valid && rdy_q) begin
               word_d  = bus.in_data;
               addr_d  = word_addr(base_q, 32'(idx_q));
               wstrb_d = 4'hF;
               valid_d = 1'b1;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (ack) begin
               valid_d = 1'b0;
               sum_d   = sum_q + word_q;
`ifdef PROG_LOAD_VERIFY_EN
               state_d = S_VERIFY;
`else
               idx_d   = idx_inc;
               state_d = (idx_inc == cnt_q) ? S_DONE : S_WAIT_DATA;
`endif
            end else if (tmr_exp) begin
               valid_d = 1'b0;
               code_d  = ERR_TIMEOUT;
               state_d = S_ERROR;
            end
         end
`ifdef PROG_LOAD_VERIFY_EN
         S_VERIFY: begin
            if (ack) begin
               valid_d = 1'b0;
               if (bus.mem_rdata != word_q) begin
                  code_d  = ERR_VERIFY;
                  state_d = S_ERROR;
               end else begin
                  idx_d   = idx_inc;
                  state_d = (idx_inc == cnt_q) ? S_DONE : S_WAIT_DATA;
               end
            end else if (tmr_exp) begin
               valid_d = 1'b0;
               code_d  = ERR_TIMEOUT;
               state_d = S_ERROR;
            end else if (!valid_q) begin
               // Read issued one cycle after the write ack drops
               valid_d = 1'b1;
               wstrb_d = 4'h0;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      rdy_d  = (state_d == S_WAIT_DATA);
      busy_d = (state_d == S_WAIT_DATA) || (state_d == S_WRITE) ||
               (state_d == S_VERIFY);
      hold_d = busy_d || (state_d == S_ERROR);
      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERROR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         word_q  <= '0;
         addr_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         wstrb_q <= '0;
         code_q  <= ERR_NONE;
         valid_q <= 1'b0;
         rdy_q   <= 1'b0;
         hold_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wstrb_q <= wstrb_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         rdy_q   <= rdy_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

`ifndef PROG_LOAD_VERIFY_EN
   logic unused_rdata;
   assign unused_rdata = ^bus.mem_rdata;
`endif

   assign bus.in_ready  = rdy_q;
   assign bus.mem_valid = valid_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = word_q;
   assign bus.mem_wstrb = wstrb_q;
   assign core_hold     = hold_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = err_q;
   assign err_code      = code_q;
   assign checksum      = sum_q;
endmodule

// File: tb/tb_prog_load_master.sv
// Self-checking bench for prog_load_master: vector table, random loads
// against a word-list model, and hand-written corner sequences.
module tb_prog_load_master;
   localparam int CNT_W = 12;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [31:0]      base_addr = '0;
   logic [CNT_W-1:0] word_count = '0;
   logic             core_hold, busy, done, error;
   logic [1:0]       err_code;
   logic [31:0]      checksum;

   prog_load_master_if bus();

   prog_load_master #(
      .TIMEOUT_CYC (255),
      .CNT_W       (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .bus        (bus),
      .core_hold  (core_hold),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_code   (err_code),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Responder and protocol monitor
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_t;

   wr_t         wlog[$];
   logic [31:0] mem_model[logic [31:0]];
   int          ack_delay = 1;
   bit          never_ack = 1'b0;
   int          bad_rd = -1;
   int          rd_cnt = 0;
   int          rsp_wait = 0;
   bit          ack_last = 1'b0;
   int          b2b_bad = 0;
   int          ir_bad = 0;
   int          valid_cycles = 0;

   always @(negedge clk) begin
      bus.mem_ready = 1'b0;
      if (ack_last && bus.mem_valid) b2b_bad++;
      ack_last = 1'b0;
      if (bus.in_ready && (bus.mem_valid || !busy)) ir_bad++;
      if (bus.mem_valid) valid_cycles++;
      if (rst) begin
         rsp_wait = 0;
      end else if (bus.mem_valid && !never_ack) begin
         if (rsp_wait >= ack_delay) begin
            bus.mem_ready = 1'b1;
            ack_last = 1'b1;
            rsp_wait = 0;
            if (bus.mem_wstrb != 4'h0) begin
               wlog.push_back('{bus.mem_addr, bus.mem_wdata, bus.mem_wstrb});
               mem_model[bus.mem_addr] = bus.mem_wdata;
            end else begin
               if (rd_cnt == bad_rd)
                  bus.mem_rdata = 32'hDEAD_BEEF;
               else if (mem_model.exists(bus.mem_addr))
                  bus.mem_rdata = mem_model[bus.mem_addr];
               else
                  bus.mem_rdata = '0;
               rd_cnt++;
            end
         end else begin
            rsp_wait++;
         end
      end else begin
         rsp_wait = 0;
      end
   end

   task automatic clear_log();
      wlog.delete();
      valid_cycles = 0;
      rd_cnt = 0;
   endtask

   task automatic do_start(input logic [31:0] b, input int n);
      start = 1'b1;
      base_addr = b;
      word_count = CNT_W'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic feed_word(input logic [31:0] w);
      int t;
      t = 0;
      bus.in_data = w;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) chk("feed_timeout", {31'b0, bus.in_ready}, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_end();
      int t;
      t = 0;
      while (!(done || error) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) chk("wait_end_timeout", {31'b0, done | error}, 1);
   endtask

   // Expected writes: word i lands at base + 4*i with full strobes
   task automatic check_writes(input string tag, input logic [31:0] b,
                               input logic [31:0] ws[$]);
      chk({tag, "_nwr"}, wlog.size(), ws.size());
      for (int i = 0; i < ws.size() && i < wlog.size(); i++) begin
         chk($sformatf("%s_addr%0d", tag, i), wlog[i].addr, b + 32'(4 * i));
         chk($sformatf("%s_data%0d", tag, i), wlog[i].data, ws[i]);
         chk($sformatf("%s_strb%0d", tag, i), {28'b0, wlog[i].strb}, 32'hF);
      end
   endtask

   function automatic logic [31:0] sum_of(input logic [31:0] ws[$]);
      logic [31:0] s;
      s = '0;
      foreach (ws[i]) s += ws[i];
      return s;
   endfunction

   typedef struct {
      logic [31:0] base;
      int          count;
      logic [31:0] seed;
      int          gap;
      int          ack;
      logic        exp_done;
      logic        exp_err;
      logic [1:0]  exp_code;
      logic [31:0] exp_sum;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [31:0] ws[$];
      logic [31:0] ew[$];
      logic [31:0] b;
      int          n, gap;

      vecs[0] = '{32'h0000_0000, 4, 32'h1, 0, 1, 1'b1, 1'b0, 2'b00, 32'hA};
      vecs[1] = '{32'h0000_0040, 0, 32'h5, 0, 1, 1'b1, 1'b0, 2'b00, 32'h0};
      vecs[2] = '{32'h0000_0002, 4, 32'h1, 0, 1, 1'b0, 1'b1, 2'b10, 32'h0};
      vecs[3] = '{32'h0000_3001, 2, 32'h1, 0, 1, 1'b0, 1'b1, 2'b10, 32'h0};
      vecs[4] = '{32'hFFFF_FFF8, 4, 32'h8000_0000, 1, 2, 1'b1, 1'b0,
                  2'b00, 32'h6};
      vecs[5] = '{32'h0000_0100, 3, 32'h100, 7, 0, 1'b1, 1'b0, 2'b00,
                  32'h303};
      vecs[6] = '{32'h0000_1000, 1, 32'hDEAD_0000, 2, 3, 1'b1, 1'b0,
                  2'b00, 32'hDEAD_0000};

      bus.in_valid = 1'b0;
      bus.in_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_error", {31'b0, error}, 0);
      chk("rst_code", {30'b0, err_code}, 0);
      chk("rst_sum", checksum, 0);
      chk("rst_hold", {31'b0, core_hold}, 0);
      chk("rst_valid", {31'b0, bus.mem_valid}, 0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         clear_log();
         ack_delay = vecs[v].ack;
         ws.delete();
         ew.delete();
         for (int i = 0; i < vecs[v].count; i++)
            ws.push_back(vecs[v].seed + 32'(i));
         if (vecs[v].exp_done) ew = ws;
         do_start(vecs[v].base, vecs[v].count);
         if (vecs[v].base[1:0] == 2'b00 && vecs[v].count > 0) begin
            chk($sformatf("v%0d_hold_load", v), {31'b0, core_hold}, 1);
            chk($sformatf("v%0d_busy_load", v), {31'b0, busy}, 1);
            chk($sformatf("v%0d_in_ready", v), {31'b0, bus.in_ready}, 1);
            foreach (ws[i]) begin
               feed_word(ws[i]);
               repeat (vecs[v].gap) @(negedge clk);
            end
         end else if (vecs[v].count == 0) begin
            chk($sformatf("v%0d_done_next", v), {31'b0, done}, 1);
         end
         wait_end();
         chk($sformatf("v%0d_done", v), {31'b0, done}, {31'b0, vecs[v].exp_done});
         chk($sformatf("v%0d_error", v), {31'b0, error}, {31'b0, vecs[v].exp_err});
         chk($sformatf("v%0d_code", v), {30'b0, err_code}, {30'b0, vecs[v].exp_code});
         chk($sformatf("v%0d_sum", v), checksum, vecs[v].exp_sum);
         chk($sformatf("v%0d_hold", v), {31'b0, core_hold}, {31'b0, vecs[v].exp_err});
         chk($sformatf("v%0d_busy", v), {31'b0, busy}, 0);
         check_writes($sformatf("v%0d", v), vecs[v].base, ew);
         if (ew.size() == 0)
            chk($sformatf("v%0d_no_valid", v), valid_cycles, 0);
      end

      // Random loads against the word-list model
      for (int r = 0; r < 10; r++) begin
         clear_log();
         b = $urandom() & 32'hFFFF_FFFC;
         if (r == 3) b = 32'hFFFF_FFF0;
         n = $urandom_range(1, 6);
         gap = $urandom_range(0, 3);
         ack_delay = $urandom_range(0, 3);
         ws.delete();
         for (int i = 0; i < n; i++) ws.push_back($urandom());
         do_start(b, n);
         foreach (ws[i]) begin
            feed_word(ws[i]);
            repeat (gap) @(negedge clk);
         end
         wait_end();
         chk($sformatf("r%0d_done", r), {31'b0, done}, 1);
         chk($sformatf("r%0d_error", r), {31'b0, error}, 0);
         chk($sformatf("r%0d_sum", r), checksum, sum_of(ws));
         chk($sformatf("r%0d_hold", r), {31'b0, core_hold}, 0);
         check_writes($sformatf("r%0d", r), b, ws);
      end

      // Gappy stream with a start pulse in the middle of the load
      clear_log();
      ack_delay = 1;
      ws = '{32'h11, 32'h22, 32'h33};
      do_start(32'h400, 3);
      feed_word(ws[0]);
      repeat (2) @(negedge clk);
      do_start(32'h804, 1);
      chk("mid_start_busy", {31'b0, busy}, 1);
      repeat (5) @(negedge clk);
      feed_word(ws[1]);
      repeat (7) @(negedge clk);
      feed_word(ws[2]);
      wait_end();
      chk("mid_done", {31'b0, done}, 1);
      chk("mid_sum", checksum, 32'h66);
      check_writes("mid", 32'h400, ws);

      // Responder never acknowledges
      clear_log();
      never_ack = 1'b1;
      do_start(32'h200, 2);
      feed_word(32'h55);
      wait_end();
      chk("to_valid_cycles", valid_cycles, 255);
      chk("to_error", {31'b0, error}, 1);
      chk("to_code", {30'b0, err_code}, 32'h1);
      chk("to_valid_low", {31'b0, bus.mem_valid}, 0);
      chk("to_hold", {31'b0, core_hold}, 1);
      chk("to_busy", {31'b0, busy}, 0);
      chk("to_sum", checksum, 0);
      chk("to_nwr", wlog.size(), 0);

      // Reset while a request is outstanding
      do_start(32'h300, 2);
      feed_word(32'h77);
      repeat (3) @(negedge clk);
      chk("rr_valid_pre", {31'b0, bus.mem_valid}, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rr_valid", {31'b0, bus.mem_valid}, 0);
      chk("rr_busy", {31'b0, busy}, 0);
      chk("rr_hold", {31'b0, core_hold}, 0);
      chk("rr_error", {31'b0, error}, 0);
      chk("rr_in_ready", {31'b0, bus.in_ready}, 0);
      rst = 1'b0;
      never_ack = 1'b0;
      @(negedge clk);

`ifdef PROG_LOAD_VERIFY_EN
      // Read-back of the second word returns garbage
      clear_log();
      ack_delay = 1;
      bad_rd = 1;
      ws = '{32'h10, 32'h20, 32'h30, 32'h40};
      do_start(32'h0, 4);
      feed_word(ws[0]);
      feed_word(ws[1]);
      wait_end();
      chk("vf_error", {31'b0, error}, 1);
      chk("vf_code", {30'b0, err_code}, 32'h3);
      chk("vf_sum", checksum, 32'h30);
      chk("vf_hold", {31'b0, core_hold}, 1);
      chk("vf_nwr", wlog.size(), 2);
      bad_rd = -1;
`endif

      chk("no_b2b_valid", b2b_bad, 0);
      chk("in_ready_only_wait", ir_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
